// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// Module   : muldiv_pkg
// Brief    : Shared CPU constants for HI/LO multiply/divide op encoding and
//            default operation latencies.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package muldiv_pkg;

  localparam logic [2:0] c_op_mult  = 3'd0;
  localparam logic [2:0] c_op_multu = 3'd1;
  localparam logic [2:0] c_op_div   = 3'd2;
  localparam logic [2:0] c_op_divu  = 3'd3;
  localparam logic [2:0] c_op_mthi  = 3'd4;
  localparam logic [2:0] c_op_mtlo  = 3'd5;

  localparam int c_mult_cyc = 5;
  localparam int c_div_cyc  = 10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } muldiv_state_t;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == c_op_mult) || (op == c_op_multu) ||
           (op == c_op_div)  || (op == c_op_divu);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// Module   : muldiv_unit
// Brief    : Fixed-latency HI/LO multiply/divide unit with MTHI/MTLO writes.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MULT_CYC = c_mult_cyc,
  parameter int DIV_CYC  = c_div_cyc
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int c_max_cyc = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

  muldiv_state_t      r_state;
  muldiv_state_t      w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_op;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic        w_counting;
  logic        w_accept;
  logic        w_start_md;
  logic        w_done;
  logic        w_signed;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_counting = (r_state == ST_COUNT);
  // Reset gating keeps busy low while reset_n is held, whatever start does.
  assign w_accept   = start & ~req & ~w_counting & reset_n;
  assign w_start_md = w_accept & is_muldiv(op);
  // Counter is loaded with N; leaving when the decrement lands on 1 gives
  // N busy cycles including the start cycle.
  assign w_done     = w_counting & (r_cnt == c_cnt_w'(2));
  assign busy       = w_start_md | w_counting;
  assign HI         = r_hi;
  assign LO         = r_lo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_md) w_state_nxt = ST_COUNT;
      ST_COUNT: if (w_done)     w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Low 64 bits of the extended product serve both signed and unsigned ops.
  assign w_signed = (r_op == c_op_mult) || (r_op == c_op_div);
  assign w_ext_a  = {{32{w_signed & r_a[31]}}, r_a};
  assign w_ext_b  = {{32{w_signed & r_b[31]}}, r_b};
  assign w_prod   = w_ext_a * w_ext_b;

  // Sign-magnitude divide: 0x80000000 / -1 naturally yields 0x80000000 rem 0.
  assign w_neg_a = w_signed & r_a[31];
  assign w_neg_b = w_signed & r_b[31];
  assign w_mag_a = w_neg_a ? -r_a : r_a;
  assign w_mag_b = w_neg_b ? -r_b : r_b;
  assign w_q_mag = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a / w_mag_b);
  assign w_r_mag = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a % w_mag_b);
  assign w_quot  = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
  assign w_rem   = w_neg_a ? -w_r_mag : w_r_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_op  <= 3'd0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_hi  <= 32'd0;
      r_lo  <= 32'd0;
    end else begin
      if (w_start_md) begin
        r_op  <= op;
        r_a   <= A;
        r_b   <= B;
        r_cnt <= ((op == c_op_mult) || (op == c_op_multu)) ?
                 c_cnt_w'(MULT_CYC) : c_cnt_w'(DIV_CYC);
      end else if (w_counting) begin
        r_cnt <= r_cnt - c_cnt_w'(1);
      end

      if (w_accept && (op == c_op_mthi)) r_hi <= A;
      if (w_accept && (op == c_op_mtlo)) r_lo <= A;

      if (w_done) begin
        if ((r_op == c_op_mult) || (r_op == c_op_multu)) begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end else if (r_b != 32'd0) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  muldiv_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .req     (req),
    .busy    (busy),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  // Issues one op for one cycle, returns the number of busy cycles seen
  // (sampled at negedges); returns at a negedge with busy low.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    n = 0;
    #1;
    if (busy) n = 1;
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; req = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = OP_MULT;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", HI); end
    checks++; if (LO !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", LO); end
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_mult;
    int n;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL mult_busy got=%0d exp=5", n); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", LO); end
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL multu_busy got=%0d exp=5", n); end
    checks++; if (HI !== 32'h0000_0002) begin failures++; $display("FAIL multu_hi got=%h exp=00000002", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffa", LO); end
  endtask

  task automatic test_div;
    int n;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
    checks++; if (n !== 10) begin failures++; $display("FAIL div_busy got=%0d exp=10", n); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, n);
    checks++; if (n !== 10) begin failures++; $display("FAIL divu_busy got=%0d exp=10", n); end
    checks++; if (LO !== 32'h7FFF_FFFC) begin failures++; $display("FAIL divu_lo got=%h exp=7ffffffc", LO); end
    checks++; if (HI !== 32'h0000_0001) begin failures++; $display("FAIL divu_hi got=%h exp=00000001", HI); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, n);
    checks++; if (LO !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_negdivisor_lo got=%h exp=fffffffd", LO); end
    checks++; if (HI !== 32'h0000_0001) begin failures++; $display("FAIL div_negdivisor_hi got=%h exp=00000001", HI); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++; if (LO !== 32'h8000_0000) begin failures++; $display("FAIL div_overflow_lo got=%h exp=80000000", LO); end
    checks++; if (HI !== 32'h0000_0000) begin failures++; $display("FAIL div_overflow_hi got=%h exp=00000000", HI); end
  endtask

  task automatic test_div_zero;
    int n;
    run_op(OP_MTHI, 32'h11, 32'd0, n);
    checks++; if (n !== 0) begin failures++; $display("FAIL mthi_busy got=%0d exp=0", n); end
    run_op(OP_MTLO, 32'h22, 32'd0, n);
    checks++; if (HI !== 32'h11 || LO !== 32'h22) begin failures++; $display("FAIL mthi_mtlo got=%h/%h exp=00000011/00000022", HI, LO); end
    run_op(OP_DIVU, 32'd100, 32'd0, n);
    checks++; if (n !== 10) begin failures++; $display("FAIL div0_busy got=%0d exp=10", n); end
    checks++; if (HI !== 32'h11) begin failures++; $display("FAIL div0_hi got=%h exp=00000011", HI); end
    checks++; if (LO !== 32'h22) begin failures++; $display("FAIL div0_lo got=%h exp=00000022", LO); end
  endtask

  task automatic test_req;
    @(negedge clk);
    start = 1'b1; req = 1'b1; op = OP_MULT; A = 32'd5; B = 32'd5;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL req_mult_busy got=%b exp=0", busy); end
    @(negedge clk);
    op = OP_MTHI; A = 32'h1234;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL req_cancel_busy got=%b exp=0", busy); end
    @(negedge clk);
    req = 1'b0; op = 3'd6; A = 32'hABCD;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL op6_busy got=%b exp=0", busy); end
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL req_idle_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'h11) begin failures++; $display("FAIL req_hi got=%h exp=00000011", HI); end
    checks++; if (LO !== 32'h22) begin failures++; $display("FAIL req_lo got=%h exp=00000022", LO); end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; A = 32'h1234_5678; B = 32'h10;
    n = 0;
    #1;
    if (busy) n = 1;
    @(negedge clk);
    op = OP_MTLO; A = 32'h0000_DEAD;
    #1;
    if (busy) n++;
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 5) begin failures++; $display("FAIL b2b_busy got=%0d exp=5", n); end
    checks++; if (LO !== 32'h2345_6780) begin failures++; $display("FAIL b2b_lo got=%h exp=23456780", LO); end
    checks++; if (HI !== 32'h0000_0001) begin failures++; $display("FAIL b2b_hi got=%h exp=00000001", HI); end
  endtask

  task automatic test_reset_mid_op;
    int n;
    @(negedge clk);
    start = 1'b1; op = OP_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy_before got=%b exp=1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midop_busy got=%b exp=0", busy); end
    checks++; if (HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL midop_hilo got=%h/%h exp=0/0", HI, LO); end
    @(negedge clk);
    reset_n = 1'b1;
    run_op(OP_MULT, 32'd3, 32'd4, n);
    checks++; if (n !== 5) begin failures++; $display("FAIL post_reset_busy got=%0d exp=5", n); end
    checks++; if (LO !== 32'd12 || HI !== 32'd0) begin failures++; $display("FAIL post_reset_mult got=%h/%h exp=0/c", HI, LO); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_req;
    test_back_to_back;
    test_reset_mid_op;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
